// File: rtl/core_run_ctrl_pkg.sv
// Shared run-control types: FSM state encodings and default timing constants.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package run_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_HOLD  = 3'd0,
    ST_PAUSE = 3'd1,
    ST_RUN   = 3'd2,
    ST_STEP  = 3'd3,
    ST_HALT  = 3'd4
  } run_state_t;

  localparam logic [15:0] DEF_DEBOUNCE_CYCLES = 16'd50000;
  localparam int          DEF_RST_HOLD_CYCLES = 16;
  localparam int          DEF_STEP_MAX_CYCLES = 32;
  localparam logic [31:0] DEF_WDOG_CYCLES     = 32'd1_000_000;

endpackage

// File: rtl/core_run_ctrl_key_debounce.sv
// Key conditioner: 2-flop synchronizer, level debouncer and one-cycle press pulse.
// Latency: 2 sync cycles + DEBOUNCE_CYCLES stable samples before level/press update.
// Backpressure: none; the press pulse is lost if the consumer ignores it.
module key_debounce
  import run_ctrl_pkg::*;
#(
  parameter logic [15:0] DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter bit          ACTIVE_LOW      = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic press
);

  // Internally 1 always means "pressed/asserted", whatever the pin polarity.
  logic raw_act;
  logic sync1;
  logic sync2;
  logic [15:0] cnt;

  assign raw_act = ACTIVE_LOW ? ~raw : raw;

  // Two-flop synchronizer for the asynchronous raw input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= raw_act;
      sync2 <= sync1;
    end
  end

  // Accept a new level only after an unbroken run of differing samples; pulse on press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level <= 1'b0;
      press <= 1'b0;
      cnt   <= 16'd0;
    end else begin
      press <= 1'b0;
      if (sync2 == level) begin
        cnt <= 16'd0;
      end else if (cnt == DEBOUNCE_CYCLES - 16'd1) begin
        level <= sync2;
        press <= sync2;
        cnt   <= 16'd0;
      end else begin
        cnt <= cnt + 16'd1;
      end
    end
  end

endmodule

// File: rtl/core_run_ctrl.sv
// Run/pause/step/halt controller for a core, with optional watchdog (RUN_CTRL_WDOG_EN).
// Latency: outputs registered (Moore); keys act 2 + DEBOUNCE_CYCLES + 1 cycles after the pin moves.
// Backpressure: none; step presses outside PAUSE are dropped, never queued.
module core_run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter logic [15:0] DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int          RST_HOLD_CYCLES = DEF_RST_HOLD_CYCLES,
  parameter int          STEP_MAX_CYCLES = DEF_STEP_MAX_CYCLES,
  parameter logic [31:0] WDOG_CYCLES     = DEF_WDOG_CYCLES
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_run_sw,
  input  logic        i_step_key,
  input  logic        i_clr_key,
  input  logic        i_insn_vld,
  input  logic        i_halt,
  output logic        o_core_en,
  output logic        o_core_rst_n,
  output logic [2:0]  o_state,
  output logic [31:0] o_retired,
  output logic        o_wdog
);

  localparam logic [15:0] HOLD_LAST = 16'(RST_HOLD_CYCLES - 1);
  localparam logic [15:0] STEP_LAST = 16'(STEP_MAX_CYCLES - 1);

  run_state_t  state_q, state_n;
  logic [15:0] hold_cnt;
  logic [15:0] step_cnt;
  logic [31:0] retired_q;
  logic        core_en_q;
  logic        core_rst_n_q;
  logic        wdog_trip;

  logic run_lvl, run_press;
  logic step_lvl, step_press;
  logic clr_lvl, clr_press;
  logic unused_key_sigs;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .ACTIVE_LOW(1'b0)) u_run_db (
    .clk(i_clk), .rst_n(i_reset), .raw(i_run_sw), .level(run_lvl), .press(run_press)
  );
  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .ACTIVE_LOW(1'b1)) u_step_db (
    .clk(i_clk), .rst_n(i_reset), .raw(i_step_key), .level(step_lvl), .press(step_press)
  );
  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .ACTIVE_LOW(1'b1)) u_clr_db (
    .clk(i_clk), .rst_n(i_reset), .raw(i_clr_key), .level(clr_lvl), .press(clr_press)
  );

  // The switch is used as a level, the keys only as press events.
  assign unused_key_sigs = ^{run_press, step_lvl, clr_lvl};

  // Next-state logic; clear press overrides everything, then halt, then watchdog.
  always_comb begin
    state_n = state_q;
    case (state_q)
      ST_HOLD:  if (hold_cnt == HOLD_LAST) state_n = run_lvl ? ST_RUN : ST_PAUSE;
      ST_RUN: begin
        if (i_halt || wdog_trip) state_n = ST_HALT;
        else if (!run_lvl)       state_n = ST_PAUSE;
      end
      ST_PAUSE: begin
        if (run_lvl)         state_n = ST_RUN;
        else if (step_press) state_n = ST_STEP;
      end
      ST_STEP: begin
        if (i_halt)                                   state_n = ST_HALT;
        else if (i_insn_vld || step_cnt == STEP_LAST) state_n = ST_PAUSE;
      end
      ST_HALT:  state_n = ST_HALT;
      default:  state_n = ST_HOLD;
    endcase
    if (clr_press) state_n = ST_HOLD;
  end

  // State, dwell counters and registered outputs decoded from the next state.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q      <= ST_HOLD;
      hold_cnt     <= 16'd0;
      step_cnt     <= 16'd0;
      core_en_q    <= 1'b0;
      core_rst_n_q <= 1'b0;
    end else begin
      state_q      <= state_n;
      hold_cnt     <= (state_q == ST_HOLD && state_n == ST_HOLD && !clr_press) ? hold_cnt + 16'd1 : 16'd0;
      step_cnt     <= (state_q == ST_STEP && state_n == ST_STEP) ? step_cnt + 16'd1 : 16'd0;
      core_en_q    <= (state_n == ST_RUN) || (state_n == ST_STEP);
      core_rst_n_q <= (state_n != ST_HOLD);
    end
  end

  // Retired count: cleared whenever heading into HOLD, wraps naturally at 32 bits.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      retired_q <= 32'd0;
    end else if (state_n == ST_HOLD) begin
      retired_q <= 32'd0;
    end else if (i_insn_vld && core_en_q) begin
      retired_q <= retired_q + 32'd1;
    end
  end

`ifdef RUN_CTRL_WDOG_EN
  logic [31:0] wdog_cnt;
  logic        wdog_q;

  assign wdog_trip = (state_q == ST_RUN) && !i_insn_vld && (wdog_cnt == WDOG_CYCLES - 32'd1);
  assign o_wdog    = wdog_q;

  // Count RUN cycles since the last commit; sticky trip flag cleared only by HOLD.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      wdog_cnt <= 32'd0;
      wdog_q   <= 1'b0;
    end else begin
      if (state_q == ST_HOLD || i_insn_vld) wdog_cnt <= 32'd0;
      else if (state_q == ST_RUN)           wdog_cnt <= wdog_cnt + 32'd1;
      if (state_n == ST_HOLD)               wdog_q <= 1'b0;
      else if (wdog_trip && !i_halt)        wdog_q <= 1'b1;
    end
  end
`else
  assign wdog_trip = 1'b0;
  assign o_wdog    = 1'b0;
`endif

  assign o_core_en    = core_en_q;
  assign o_core_rst_n = core_rst_n_q;
  assign o_state      = state_q;
  assign o_retired    = retired_q;

endmodule
